// File: rtl/vote_collector.sv
// +------------------------------------------------------------------------+
// | vote_collector: sequential 4-voter ballot collector with dedup,        |
// | round timeout and a held verdict released by a valid/ready handshake.  |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
`default_nettype none

module vote_collector #(
  parameter int TIMEOUT = 16,
  parameter int ROUND_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ballot_valid,
  output logic               ballot_ready,
  input  logic [1:0]         ballot_id,
  input  logic               ballot_yes,
  output logic               result_valid,
  input  logic               result_ready,
  output logic [2:0]         yes_count,
  output logic [1:0]         verdict,
  output logic               timed_out,
  output logic               dup_err,
  output logic [ROUND_W-1:0] round_cnt
);

  typedef enum logic [0:0] {
    COLLECT = 1'b0,
    DONE    = 1'b1
  } state_t;

  // The timer is compared before its increment, so the round closes on the
  // edge where it would reach TIMEOUT-1.
  localparam logic [7:0] C_TIMER_LAST = 8'(TIMEOUT - 2);

  state_t             state_q, state_d;
  logic [3:0]         mask_q, mask_d;
  logic [2:0]         tally_q, tally_d;
  logic [7:0]         timer_q, timer_d;
  logic               armed_q, armed_d;
  logic               rv_q, rv_d;
  logic [2:0]         yc_q, yc_d;
  logic [1:0]         verdict_q, verdict_d;
  logic               to_q, to_d;
  logic               dup_q, dup_d;
  logic [ROUND_W-1:0] rc_q, rc_d;

  logic       w_accept;
  logic       w_is_dup;
  logic       w_complete;
  logic       w_expire;
  logic [3:0] w_id_onehot;

  assign ballot_ready = (state_q == COLLECT) && rst_n;
  assign w_accept     = ballot_valid && ballot_ready;
  assign w_id_onehot  = 4'b0001 << ballot_id;
  assign w_is_dup     = (mask_q & w_id_onehot) != 4'b0000;

  always_comb begin
    state_d    = state_q;
    mask_d     = mask_q;
    tally_d    = tally_q;
    timer_d    = timer_q;
    armed_d    = armed_q;
    rv_d       = rv_q;
    yc_d       = yc_q;
    verdict_d  = verdict_q;
    to_d       = to_q;
    rc_d       = rc_q;
    dup_d      = w_accept && w_is_dup;
    w_complete = 1'b0;
    w_expire   = 1'b0;

    case (state_q)
      COLLECT: begin
        if (w_accept && !w_is_dup) begin
          mask_d  = mask_q | w_id_onehot;
          tally_d = tally_q + {2'b00, ballot_yes};
          armed_d = 1'b1;
        end
        if (armed_q) begin
          timer_d = timer_q + 8'd1;
        end else if (w_accept) begin
          timer_d = 8'd0;
        end

        w_complete = (mask_d == 4'b1111);
        w_expire   = armed_q && (timer_q == C_TIMER_LAST);

        if (w_complete || w_expire) begin
          state_d   = DONE;
          rv_d      = 1'b1;
          yc_d      = tally_d;
          to_d      = !w_complete;
          rc_d      = rc_q + ROUND_W'(1);
          if (tally_d >= 3'd3) begin
            verdict_d = 2'b01;
          end else if (tally_d == 3'd2) begin
            verdict_d = 2'b10;
          end else begin
            verdict_d = 2'b00;
          end
        end
      end

      DONE: begin
        if (rv_q && result_ready) begin
          state_d = COLLECT;
          rv_d    = 1'b0;
          mask_d  = 4'b0000;
          tally_d = 3'd0;
          timer_d = 8'd0;
          armed_d = 1'b0;
        end
      end

      default: begin
        state_d = COLLECT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= COLLECT;
      mask_q    <= 4'b0000;
      tally_q   <= 3'd0;
      timer_q   <= 8'd0;
      armed_q   <= 1'b0;
      rv_q      <= 1'b0;
      yc_q      <= 3'd0;
      verdict_q <= 2'b00;
      to_q      <= 1'b0;
      dup_q     <= 1'b0;
      rc_q      <= '0;
    end else begin
      state_q   <= state_d;
      mask_q    <= mask_d;
      tally_q   <= tally_d;
      timer_q   <= timer_d;
      armed_q   <= armed_d;
      rv_q      <= rv_d;
      yc_q      <= yc_d;
      verdict_q <= verdict_d;
      to_q      <= to_d;
      dup_q     <= dup_d;
      rc_q      <= rc_d;
    end
  end

  assign result_valid = rv_q;
  assign yes_count    = yc_q;
  assign verdict      = verdict_q;
  assign timed_out    = to_q;
  assign dup_err      = dup_q;
  assign round_cnt    = rc_q;

endmodule

`default_nettype wire
